serial_paralelo_sync: RTL and testbench
=======================================

SERIAL_PARALELO_SYNC -- requirements
Module: serial_paralelo_sync

Interface
REQ-001 Parameter WIDTH, default 8: bits per parallel word; legal range 4..32.
REQ-002 Parameter BC_PATTERN, default 8'hBC, WIDTH bits: comma/idle symbol used for alignment and IDL detection.
REQ-003 Parameter BC_LOCK, default 4: consecutive aligned BC words required to assert active.
REQ-004 Parameter LOSS_LIMIT, default 2: consecutive aligned invalid words (not BC, while in ALIGN) that force return to SEARCH.
REQ-005 Port clk_32f, input, 1: the only clock; one serial bit per rising edge. Reset is synchronous and active-high.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port data_in, input, 1: serial bit stream, MSB of each word first.
REQ-008 Port data_out, output, WIDTH: last aligned non-BC word.
REQ-009 Port valid_out, output, 1: one-cycle strobe; data_out holds a new word.
REQ-010 Port active, output, 1: link locked, data words being delivered.
REQ-011 Port IDL, output, 1: high while the most recent aligned word was BC_PATTERN.

Function
REQ-012 Each edge: shift register sr <= {sr[WIDTH-2:0], data_in}; bit counter cnt increments modulo WIDTH.
REQ-013 States: SEARCH, ALIGN, ACTIVE; encoding 2 bits, held in a register.
REQ-014 SEARCH: next sr compared to BC_PATTERN every cycle; on match, cnt forced to 0 (word boundary), bc_count <= 1, go to ALIGN.
REQ-015 ALIGN: compare only at word boundary (cnt == WIDTH-1 on the next-sr value); BC -> bc_count+1; when bc_count reaches BC_LOCK, go to ACTIVE in the same cycle, active registered high on that edge.
REQ-016 ALIGN: non-BC at boundary -> bc_count <= 0, miss_count+1; miss_count reaching LOSS_LIMIT -> SEARCH; BC resets miss_count.
REQ-017 ACTIVE: at each boundary, non-BC word -> data_out <= word, valid_out <= 1 for exactly one cycle, IDL <= 0; BC word -> data_out unchanged, valid_out 0, IDL <= 1.
REQ-018 ACTIVE is left only by reset; BC words in ACTIVE never drop active.
REQ-019 Latency: valid_out/IDL/data_out registered on the edge that samples the word's last bit (visible the following cycle); no further pipelining.
REQ-020 IDL updates only at boundaries in ALIGN/ACTIVE; in SEARCH IDL is 0.
REQ-021 valid_out never asserted outside ACTIVE; never two consecutive cycles when WIDTH >= 2.
REQ-022 bc_count and miss_count saturate; width clog2(max(BC_LOCK,LOSS_LIMIT))+1.
REQ-023 BC_PATTERN appearing misaligned in ALIGN/ACTIVE shall not re-align cnt.

Reset
REQ-024 reset high at an edge: state SEARCH, sr 0, cnt 0, bc_count 0, miss_count 0, data_out 0, valid_out 0, active 0, IDL 0.
REQ-025 reset mid-word or mid-lock discards the partial word and lock; first post-reset edge samples data_in as bit 0 of a fresh search.
REQ-026 reset has priority over all state transitions in the same cycle.

Structure
REQ-027 Shared package serial_paralelo_pkg holds state encoding constants (SEARCH/ALIGN/ACTIVE) and default BC_PATTERN.
REQ-028 One sub-module, bc_detector: WIDTH-bit comparator of next-sr against BC_PATTERN, pure combinational; all state in serial_paralelo_sync.
REQ-029 Target size 120-400 lines RTL total.

Verification
REQ-030 reset 4 cycles, then 4 aligned 8'hBC words -> active rises the edge sampling the last bit of 4th BC; IDL 1; valid_out 0 throughout.
REQ-031 After lock send 8'h5A, 8'hBC, 8'hF0 -> valid_out pulses with data_out 8'h5A then 8'hF0; IDL 0,1,0 at respective boundaries.
REQ-032 3 junk bits then BC stream -> alignment found at offset 3; data words after lock match transmitted values exactly.
REQ-033 Lock in progress (2 BC) then 2 non-BC words -> state back to SEARCH, active stays 0, IDL 0.
REQ-034 Reset asserted one cycle mid-word in ACTIVE -> all outputs 0 next cycle; relock needs full BC_LOCK BCs.
REQ-035 Rerun REQ-030/031 with WIDTH=10, BC_PATTERN=10'h17C, BC_LOCK=2 -> identical behaviour scaled to 10-bit words.

Source files
------------

// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: FSM encoding,
// default comma symbol and a small parameter helper.
package serial_paralelo_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [7:0] BC_DEFAULT = 8'hBC;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bc_detector.sv
// Pure combinational comparator of a candidate word against the comma symbol.
module bc_detector
    import serial_paralelo_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(BC_DEFAULT)
) (
    input  logic [WIDTH-1:0] word,
    output logic             match
);

    assign match = (word == PATTERN);

endmodule

// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel deserializer: hunts for the comma symbol, locks after
// BC_LOCK aligned commas, then delivers every aligned non-comma word.
module serial_paralelo_sync
    import serial_paralelo_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] BC_PATTERN = WIDTH'(BC_DEFAULT),
    parameter int               BC_LOCK    = 4,
    parameter int               LOSS_LIMIT = 2
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic             IDL,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int RUN_W = $clog2(max2(BC_LOCK, LOSS_LIMIT)) + 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [RUN_W-1:0] LOCK_M1  = RUN_W'(BC_LOCK - 1);
    localparam logic [RUN_W-1:0] LOSS_M1  = RUN_W'(LOSS_LIMIT - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;

    state_t           state, state_nxt;
    logic [WIDTH-2:0] sr, sr_nxt;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RUN_W-1:0] bc_count, bc_nxt;
    logic [RUN_W-1:0] miss_count, miss_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             valid_nxt, active_nxt, idl_nxt;
    logic             bc_match, at_boundary;

    // Only the newest WIDTH-1 bits are stored; data_in completes the word,
    // so every decision is made on the value the shift register is about to hold.
    assign word        = {sr, data_in};
    assign sr_nxt      = word[WIDTH-2:0];
    assign at_boundary = (cnt == LAST_BIT);
    assign state_dbg   = state;

    bc_detector #(
        .WIDTH   (WIDTH),
        .PATTERN (BC_PATTERN)
    ) u_bc_detector (
        .word  (word),
        .match (bc_match)
    );

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state      <= SEARCH;
            sr         <= '0;
            cnt        <= '0;
            bc_count   <= '0;
            miss_count <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            active     <= 1'b0;
            IDL        <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            cnt        <= cnt_nxt;
            bc_count   <= bc_nxt;
            miss_count <= miss_nxt;
            data_out   <= data_nxt;
            valid_out  <= valid_nxt;
            active     <= active_nxt;
            IDL        <= idl_nxt;
        end
    end

    // valid_out is a one-cycle strobe with no back-pressure: the consumer must
    // take data_out in the cycle valid_out is high; data_out then holds until the next word.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = at_boundary ? '0 : cnt + CNT_W'(1);
        bc_nxt     = bc_count;
        miss_nxt   = miss_count;
        data_nxt   = data_out;
        valid_nxt  = 1'b0;
        active_nxt = active;
        idl_nxt    = IDL;

        case (state)
            SEARCH: begin
                idl_nxt    = 1'b0;
                active_nxt = 1'b0;
                if (bc_match) begin
                    cnt_nxt   = '0;
                    bc_nxt    = RUN_W'(1);
                    miss_nxt  = '0;
                    state_nxt = ALIGN;
                end
            end

            ALIGN: begin
                if (at_boundary) begin
                    if (bc_match) begin
                        idl_nxt  = 1'b1;
                        miss_nxt = '0;
                        bc_nxt   = (bc_count == RUN_MAX) ? bc_count : bc_count + RUN_W'(1);
                        if (bc_count >= LOCK_M1) begin
                            state_nxt  = ACTIVE;
                            active_nxt = 1'b1;
                        end
                    end else begin
                        idl_nxt  = 1'b0;
                        bc_nxt   = '0;
                        miss_nxt = (miss_count == RUN_MAX) ? miss_count : miss_count + RUN_W'(1);
                        if (miss_count >= LOSS_M1) begin
                            state_nxt = SEARCH;
                        end
                    end
                end
            end

            ACTIVE: begin
                // Lock is only released by reset; commas here are idle fill.
                if (at_boundary) begin
                    if (bc_match) begin
                        idl_nxt = 1'b1;
                    end else begin
                        idl_nxt   = 1'b0;
                        data_nxt  = word;
                        valid_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Self-checking bench for serial_paralelo_sync: an 8-bit and a 10-bit instance
// driven in turn, checked every cycle against a word-level reference model.
module tb_serial_paralelo_sync;
    import serial_paralelo_pkg::*;

    localparam int HUNT   = 0;
    localparam int TRAIN  = 1;
    localparam int LOCKED = 2;

    typedef struct {
        int          mode;
        int          pos;
        int          bcs;
        int          misses;
        logic [31:0] hist;
        logic [31:0] data;
        bit          valid;
        bit          act;
        bit          idl;
    } model_t;

    logic       clk_32f = 1'b0;
    logic       reset8, reset10, data_in8, data_in10;
    logic [7:0] data_out8;
    logic [9:0] data_out10;
    logic       valid8, valid10, active8, active10, idl8, idl10;
    logic [1:0] st8, st10;

    int     total = 0;
    int     bad   = 0;
    int     vcnt8 = 0;
    int     vcnt10 = 0;
    bit     cmp_en = 1'b0;
    model_t m8, m10;

    // ---------------- clock ----------------
    always #5 clk_32f = ~clk_32f;

    serial_paralelo_sync dut8 (
        .clk_32f   (clk_32f),
        .reset     (reset8),
        .data_in   (data_in8),
        .data_out  (data_out8),
        .valid_out (valid8),
        .active    (active8),
        .IDL       (idl8),
        .state_dbg (st8)
    );

    serial_paralelo_sync #(
        .WIDTH      (10),
        .BC_PATTERN (10'h17C),
        .BC_LOCK    (2),
        .LOSS_LIMIT (2)
    ) dut10 (
        .clk_32f   (clk_32f),
        .reset     (reset10),
        .data_in   (data_in10),
        .data_out  (data_out10),
        .valid_out (valid10),
        .active    (active10),
        .IDL       (idl10),
        .state_dbg (st10)
    );

    // ---------------- reference model ----------------
    function automatic model_t model_clear();
        model_t r;
        r.mode = HUNT; r.pos = 0; r.bcs = 0; r.misses = 0;
        r.hist = '0; r.data = '0; r.valid = 0; r.act = 0; r.idl = 0;
        return r;
    endfunction

    // One received bit: words are counted in bits since the last boundary.
    function automatic model_t model_step(model_t m, bit b, bit rst, int w,
                                          logic [31:0] pat, int lock, int loss);
        model_t      r;
        logic [31:0] mask;
        if (rst) return model_clear();
        r = m;
        mask = (32'h1 << w) - 32'h1;
        r.valid = 0;
        r.hist = ((m.hist << 1) | 32'(b)) & mask;
        if (m.mode == HUNT) begin
            if (r.hist == pat) begin
                r.mode = TRAIN; r.pos = 0; r.bcs = 1; r.misses = 0;
            end
        end else begin
            r.pos = m.pos + 1;
            if (r.pos == w) begin
                r.pos = 0;
                if (r.hist == pat) begin
                    r.idl = 1;
                    if (m.mode == TRAIN) begin
                        r.bcs = m.bcs + 1;
                        r.misses = 0;
                        if (r.bcs >= lock) begin
                            r.mode = LOCKED;
                            r.act = 1;
                        end
                    end
                end else begin
                    r.idl = 0;
                    if (m.mode == LOCKED) begin
                        r.data = r.hist;
                        r.valid = 1;
                    end else begin
                        r.bcs = 0;
                        r.misses = m.misses + 1;
                        if (r.misses >= loss) r.mode = HUNT;
                    end
                end
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk_32f) begin
        if (cmp_en) begin
            cmp("stream_w8", {29'd0, active8, idl8, valid8, 24'd0, data_out8},
                {29'd0, m8.act, m8.idl, m8.valid, m8.data});
            cmp("stream_w10", {29'd0, active10, idl10, valid10, 22'd0, data_out10},
                {29'd0, m10.act, m10.idl, m10.valid, m10.data});
            if (valid8 === 1'b1) vcnt8++;
            if (valid10 === 1'b1) vcnt10++;
        end
    end

    // ---------------- driver ----------------
    function automatic int wd(input int which);
        return (which == 0) ? 8 : 10;
    endfunction

    function automatic logic [31:0] pt(input int which);
        return (which == 0) ? 32'hBC : 32'h17C;
    endfunction

    function automatic int lk(input int which);
        return (which == 0) ? 4 : 2;
    endfunction

    function automatic int vc(input int which);
        return (which == 0) ? vcnt8 : vcnt10;
    endfunction

    task automatic tick(input bit b8, input bit b10, input bit r8, input bit r10);
        data_in8 = b8; data_in10 = b10; reset8 = r8; reset10 = r10;
        @(posedge clk_32f);
        m8  = model_step(m8, b8, r8, 8, 32'hBC, 4, 2);
        m10 = model_step(m10, b10, r10, 10, 32'h17C, 2, 2);
        @(negedge clk_32f);
    endtask

    task automatic send_range(input int which, input logic [31:0] w, input int width,
                              input int first, input int last);
        bit b;
        for (int i = first; i < last; i++) begin
            b = w[width-1-i];
            tick((which == 0) ? b : 1'b0, (which == 1) ? b : 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_word(input int which, input logic [31:0] w);
        send_range(which, w, wd(which), 0, wd(which));
    endtask

    task automatic pulse_reset(input int which, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, which == 0, which == 1);
    endtask

    task automatic pin(input string name, input int which, input logic [31:0] d,
                       input bit v, input bit a, input bit i);
        string nm;
        nm = $sformatf("%s_w%0d", name, wd(which));
        if (which == 0)
            cmp(nm, {29'd0, active8, idl8, valid8, 24'd0, data_out8}, {29'd0, a, i, v, d});
        else
            cmp(nm, {29'd0, active10, idl10, valid10, 22'd0, data_out10}, {29'd0, a, i, v, d});
    endtask

    task automatic pin_state(input string name, input int which, input state_t s);
        cmp($sformatf("%s_w%0d", name, wd(which)), 64'((which == 0) ? st8 : st10), 64'(s));
    endtask

    // ---------------- directed sequences ----------------
    task automatic lock_sequence(input int which);
        int          w, lkw, v0;
        logic [31:0] p;
        w = wd(which); p = pt(which); lkw = lk(which);
        pulse_reset(which, 4);
        pin("reset", which, 0, 0, 0, 0);
        pin_state("reset_state", which, SEARCH);
        v0 = vc(which);
        send_word(which, p);
        pin_state("first_bc_state", which, ALIGN);
        pin("first_bc", which, 0, 0, 0, 0);
        for (int k = 1; k < lkw - 1; k++) send_word(which, p);
        send_range(which, p, w, 0, w - 1);
        pin("pre_lock", which, 0, 0, 0, lkw >= 3);
        send_range(which, p, w, w - 1, w);
        pin("lock", which, 0, 0, 1, 1);
        pin_state("lock_state", which, ACTIVE);
        cmp($sformatf("model_lock_w%0d", w), 64'((which == 0) ? m8.act : m10.act), 64'd1);
        cmp($sformatf("lock_no_valid_w%0d", w), 64'(vc(which) - v0), 64'd0);
        send_word(which, 32'h5A);
        pin("word_5a", which, 32'h5A, 1, 1, 0);
        send_word(which, p);
        pin("word_bc", which, 32'h5A, 0, 1, 1);
        send_word(which, 32'hF0);
        pin("word_f0", which, 32'hF0, 1, 1, 0);
        send_range(which, 32'h0, w, 0, 3);
        pin("strobe_drop", which, 32'hF0, 0, 1, 0);
        pulse_reset(which, 1);
        pin("mid_reset", which, 0, 0, 0, 0);
        pin_state("mid_reset_state", which, SEARCH);
        for (int k = 0; k < lkw - 1; k++) send_word(which, p);
        pin("relock_pending", which, 0, 0, 0, lkw >= 3);
        send_word(which, p);
        pin("relock", which, 0, 0, 1, 1);
    endtask

    task automatic loss_sequence();
        pulse_reset(0, 2);
        send_word(0, 32'hBC);
        send_word(0, 32'hBC);
        pin("two_bc", 0, 0, 0, 0, 1);
        send_word(0, 32'h00);
        pin_state("miss1_state", 0, ALIGN);
        pin("miss1", 0, 0, 0, 0, 0);
        send_word(0, 32'h00);
        pin_state("loss_state", 0, SEARCH);
        pin("loss", 0, 0, 0, 0, 0);
    endtask

    task automatic offset_sequence();
        logic [31:0] d;
        pulse_reset(0, 2);
        send_range(0, 32'h5, 3, 0, 3);
        send_range(0, 32'hBC, 8, 0, 7);
        pin_state("offset_pre", 0, SEARCH);
        send_range(0, 32'hBC, 8, 7, 8);
        pin_state("offset_hit", 0, ALIGN);
        for (int k = 0; k < 3; k++) send_word(0, 32'hBC);
        pin("offset_lock", 0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            d = 32'($urandom_range(0, 255));
            if (d == 32'hBC) d = 32'h3C;
            send_word(0, d);
            pin("offset_word", 0, d, 1, 1, 0);
        end
    endtask

    task automatic random_phase(input int which, input int nwords);
        int r, w;
        w = wd(which);
        pulse_reset(which, 2);
        for (int n = 0; n < nwords; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3) pulse_reset(which, 1);
            else if (r < 10) send_range(which, $urandom, w, 0, $urandom_range(1, w - 1));
            else if (r < 65) send_word(which, pt(which));
            else send_word(which, $urandom);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        reset8 = 1'b1; reset10 = 1'b1; data_in8 = 1'b0; data_in10 = 1'b0;
        m8 = model_clear();
        m10 = model_clear();
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        cmp_en = 1'b1;
        lock_sequence(0);
        lock_sequence(1);
        loss_sequence();
        offset_sequence();
        random_phase(0, 300);
        random_phase(1, 300);
        @(negedge clk_32f);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
